// File: rtl/trisc_ctrl_seq.sv
// trisc_ctrl_seq: one-hot T-state ring with registered instruction decode, jump resolution and halt/resume
module trisc_ctrl_seq #(
    parameter int IW    = 8,
    parameter int NT    = 6,
    parameter int FETCH = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [IW-1:0] IR,
    input  logic          ZF,
    input  logic          NF,
    input  logic          RUN,
    output logic [NT-1:0] T,
    output logic [10:0]   ID,
    output logic          ILL,
    output logic          JMP_TAKEN,
    output logic          HALTED
);
    logic [3:0]    op;
    logic [10:0]   dec_id;
    logic          jmp_res;
    logic [NT-1:0] t_q, t_d;
    logic [10:0]   id_q, id_d;
    logic          ill_q, ill_d;
    logic          jt_q, jt_d;
    logic          halted_q, halted_d;

    assign op = IR[IW-1:IW-4];

    if (IW > 4) begin : g_unused
        logic unused_ir;
        assign unused_ir = ^IR[IW-5:0];
    end

    // One-hot decode of the opcode; undefined opcodes decode to all zeros
    always_comb begin
        dec_id = '0;
        case (op)
            4'h0: dec_id[0] = 1'b1;
            4'h1: dec_id[1] = 1'b1;
            4'h2: dec_id[2] = 1'b1;
            4'h3: dec_id[3] = 1'b1;
            4'h4: dec_id[4] = 1'b1;
            4'h6: dec_id[5] = 1'b1;
            4'h7: dec_id[6] = 1'b1;
            4'h8: dec_id[7] = 1'b1;
            4'hC: dec_id[8] = 1'b1;
            4'h9: dec_id[9] = 1'b1;
            4'hF: dec_id[10] = 1'b1;
            default: dec_id = '0;
        endcase
    end

    assign jmp_res = dec_id[7] | (dec_id[8] & ZF) | (dec_id[9] & NF);

    // Next state: resume while halted, freeze on HLT in the first execute state, otherwise rotate the ring
    always_comb begin
        t_d      = t_q;
        id_d     = id_q;
        ill_d    = ill_q;
        jt_d     = jt_q;
        halted_d = halted_q;
        if (EN) begin
            if (halted_q) begin
                if (RUN) begin
                    t_d      = NT'(1);
                    id_d     = '0;
                    ill_d    = 1'b0;
                    jt_d     = 1'b0;
                    halted_d = 1'b0;
                end
            end else if (t_q[FETCH] && id_q[10]) begin
                halted_d = 1'b1;
            end else begin
                t_d = {t_q[NT-2:0], t_q[NT-1]};
                if (t_q[FETCH-1]) begin
                    id_d  = dec_id;
                    ill_d = ~|dec_id;
                    jt_d  = jmp_res;
                end else if (t_q[NT-1]) begin
                    id_d  = '0;
                    ill_d = 1'b0;
                    jt_d  = 1'b0;
                end
            end
        end
    end

    // State registers with asynchronous reset to T0 and cleared decode
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            t_q      <= NT'(1);
            id_q     <= '0;
            ill_q    <= 1'b0;
            jt_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            t_q      <= t_d;
            id_q     <= id_d;
            ill_q    <= ill_d;
            jt_q     <= jt_d;
            halted_q <= halted_d;
        end
    end

    assign T         = t_q;
    assign ID        = id_q;
    assign ILL       = ill_q;
    assign JMP_TAKEN = jt_q;
    assign HALTED    = halted_q;
endmodule

// File: tb/tb_trisc_ctrl_seq.sv
// tb_trisc_ctrl_seq: randomized and directed checks of trisc_ctrl_seq against a phase-counter reference model
module tb_trisc_ctrl_seq;
    localparam int IW = 8;
    localparam int NT = 6;
    localparam int FETCH = 3;
    localparam int W = NT + 14;
    localparam logic [3:0] OPC [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'hC, 4'h9, 4'hF};

    logic          CLK, RST, EN, ZF, NF, RUN;
    logic [IW-1:0] IR;
    logic [NT-1:0] T;
    logic [10:0]   ID;
    logic          ILL, JMP_TAKEN, HALTED;

    int vec = 0;
    int err = 0;

    int          m_phase;
    logic        m_halted, m_ill, m_jt;
    logic [10:0] m_id;

    trisc_ctrl_seq #(.IW(IW), .NT(NT), .FETCH(FETCH)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .IR(IR), .ZF(ZF), .NF(NF), .RUN(RUN),
        .T(T), .ID(ID), .ILL(ILL), .JMP_TAKEN(JMP_TAKEN), .HALTED(HALTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [10:0] ref_dec(input logic [3:0] op);
        logic [10:0] r;
        r = '0;
        for (int i = 0; i < 11; i++) if (OPC[i] == op) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] exp_vec();
        logic [NT-1:0] t;
        t = 1;
        t = t << m_phase;
        return {t, m_id, m_ill, m_jt, m_halted};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_halted = 0;
        m_ill = 0;
        m_jt = 0;
        m_id = '0;
    endtask

    task automatic step();
        logic [10:0] d;
        @(posedge CLK);
        if (EN) begin
            if (m_halted) begin
                if (RUN) begin
                    model_reset();
                end
            end else if (m_phase == FETCH && m_id[10]) begin
                m_halted = 1;
            end else begin
                if (m_phase == FETCH - 1) begin
                    d = ref_dec(IR[IW-1:IW-4]);
                    m_id = d;
                    m_ill = (d == 0);
                    m_jt = d[7] | (d[8] & ZF) | (d[9] & NF);
                end else if (m_phase == NT - 1) begin
                    m_id = '0;
                    m_ill = 0;
                    m_jt = 0;
                end
                m_phase = (m_phase + 1) % NT;
            end
        end
        #1;
    endtask

    task automatic goto_phase(input int p);
        int n;
        n = 0;
        while (!(m_phase == p && !m_halted) && n < 100) begin
            RUN = m_halted;
            step();
            n++;
        end
        RUN = 0;
        vec++;
        if (n >= 100) begin
            err++;
            $display("FAIL goto_phase: phase %0d not reached, model phase %0d", p, m_phase);
        end
    endtask

    task automatic test_reset();
        RST = 1; EN = 0; IR = '0; ZF = 0; NF = 0; RUN = 0;
        model_reset();
        #12;
        vec++;
        if ({T, ID, ILL, JMP_TAKEN, HALTED} !== {6'b000001, 11'h0, 3'b000}) begin
            err++;
            $display("FAIL reset: got %h exp %h", {T, ID, ILL, JMP_TAKEN, HALTED}, {6'b000001, 11'h0, 3'b000});
        end
        @(negedge CLK);
        RST = 0;
        EN = 1;
    endtask

    task automatic test_ring();
        logic [NT-1:0] seq [7] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01, 6'h02};
        IR = 8'h20;
        for (int i = 0; i < 7; i++) begin
            step();
            vec++;
            if (T !== seq[i] || {T, ID, ILL, JMP_TAKEN, HALTED} !== exp_vec()) begin
                err++;
                $display("FAIL ring[%0d]: got %h exp T %h vec %h", i, {T, ID, ILL, JMP_TAKEN, HALTED}, seq[i], exp_vec());
            end
        end
    endtask

    task automatic test_decode();
        for (int i = 0; i < 11; i++) begin
            goto_phase(0);
            IR = {OPC[i], 4'($urandom)};
            ZF = 1'($urandom);
            NF = 1'($urandom);
            for (int s = 0; s < NT; s++) begin
                step();
                if (m_phase == FETCH) begin
                    vec++;
                    if (ID !== (11'd1 << i) || ILL !== 1'b0) begin
                        err++;
                        $display("FAIL decode op %h: ID %h ILL %b exp %h 0", OPC[i], ID, ILL, 11'd1 << i);
                    end
                    IR = 8'($urandom);
                end
                vec++;
                if ({T, ID, ILL, JMP_TAKEN, HALTED} !== exp_vec()) begin
                    err++;
                    $display("FAIL decode op %h s%0d: got %h exp %h", OPC[i], s, {T, ID, ILL, JMP_TAKEN, HALTED}, exp_vec());
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] bad [5] = '{4'h5, 4'hA, 4'hB, 4'hD, 4'hE};
        for (int i = 0; i < 5; i++) begin
            goto_phase(0);
            IR = {bad[i], 4'hF};
            for (int s = 0; s < NT; s++) begin
                step();
                vec++;
                if ({T, ID, ILL, JMP_TAKEN, HALTED} !== exp_vec() || (s >= FETCH - 1 && s < NT - 1 && (ILL !== 1'b1 || ID !== 11'h0))) begin
                    err++;
                    $display("FAIL illegal op %h s%0d: got %h exp %h", bad[i], s, {T, ID, ILL, JMP_TAKEN, HALTED}, exp_vec());
                end
            end
        end
    endtask

    task automatic run_jump(input logic [7:0] ir, input logic zf, input logic nf, input logic [10:0] eid, input logic ejt);
        goto_phase(0);
        IR = ir; ZF = zf; NF = nf;
        for (int s = 0; s < FETCH; s++) step();
        ZF = ~zf; NF = ~nf; IR = 8'h00;
        for (int s = FETCH; s < NT; s++) begin
            vec++;
            if (ID !== eid || JMP_TAKEN !== ejt || {T, ID, ILL, JMP_TAKEN, HALTED} !== exp_vec()) begin
                err++;
                $display("FAIL jump %h s%0d: ID %h JT %b exp %h %b", ir, s, ID, JMP_TAKEN, eid, ejt);
            end
            step();
        end
    endtask

    task automatic test_jumps();
        run_jump(8'hC3, 1, 0, 11'h100, 1);
        run_jump(8'hC3, 0, 1, 11'h100, 0);
        run_jump(8'h91, 0, 1, 11'h200, 1);
        run_jump(8'h91, 1, 0, 11'h200, 0);
        run_jump(8'h85, 0, 0, 11'h080, 1);
    endtask

    task automatic test_halt();
        goto_phase(0);
        IR = 8'hF0;
        for (int s = 0; s < FETCH; s++) step();
        IR = 8'h20;
        vec++;
        if (T !== 6'b001000 || HALTED !== 1'b0 || ID !== 11'h400) begin
            err++;
            $display("FAIL halt_entry: T %h HALTED %b ID %h exp 08 0 400", T, HALTED, ID);
        end
        for (int s = 0; s < 11; s++) begin
            step();
            vec++;
            if (T !== 6'b001000 || HALTED !== 1'b1 || {T, ID, ILL, JMP_TAKEN, HALTED} !== exp_vec()) begin
                err++;
                $display("FAIL halt_hold[%0d]: got %h exp %h", s, {T, ID, ILL, JMP_TAKEN, HALTED}, exp_vec());
            end
        end
        RUN = 1;
        step();
        RUN = 0;
        vec++;
        if ({T, ID, ILL, JMP_TAKEN, HALTED} !== {6'b000001, 11'h0, 3'b000}) begin
            err++;
            $display("FAIL resume: got %h exp %h", {T, ID, ILL, JMP_TAKEN, HALTED}, {6'b000001, 11'h0, 3'b000});
        end
    endtask

    task automatic test_enable();
        IR = 8'h20;
        goto_phase(4);
        EN = 0;
        RUN = 1;
        for (int s = 0; s < 3; s++) begin
            IR = 8'($urandom);
            step();
            vec++;
            if (T !== 6'b010000 || ID !== 11'h004 || {T, ID, ILL, JMP_TAKEN, HALTED} !== exp_vec()) begin
                err++;
                $display("FAIL enable_hold[%0d]: got %h exp %h", s, {T, ID, ILL, JMP_TAKEN, HALTED}, exp_vec());
            end
        end
        EN = 1;
        RUN = 0;
    endtask

    task automatic test_async_reset();
        IR = 8'h20;
        goto_phase(4);
        #2;
        RST = 1;
        model_reset();
        #1;
        vec++;
        if ({T, ID, ILL, JMP_TAKEN, HALTED} !== {6'b000001, 11'h0, 3'b000}) begin
            err++;
            $display("FAIL async_reset: got %h exp %h", {T, ID, ILL, JMP_TAKEN, HALTED}, {6'b000001, 11'h0, 3'b000});
        end
        #1;
        RST = 0;
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            IR = 8'($urandom);
            ZF = 1'($urandom);
            NF = 1'($urandom);
            EN = ($urandom % 8) != 0;
            RUN = ($urandom % 4) == 0;
            step();
            vec++;
            if ({T, ID, ILL, JMP_TAKEN, HALTED} !== exp_vec()) begin
                err++;
                $display("FAIL random[%0d]: got %h exp %h", s, {T, ID, ILL, JMP_TAKEN, HALTED}, exp_vec());
            end
        end
        EN = 1;
        RUN = 0;
    endtask

    initial begin
        test_reset();
        test_ring();
        test_decode();
        test_illegal();
        test_jumps();
        test_halt();
        test_enable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/trisc_ctrl_seq.md
# trisc_ctrl_seq

Parametrised control sequencer for the TRISC processor. Combines a one-hot T-state ring counter with a registered one-hot instruction decoder, conditional-jump resolution and halt/resume control. It takes the instruction register contents and ALU flags, and drives the T-state and decoded-instruction buses that the datapath control logic ANDs together to form its control signals.

## Interface
Parameters:
- IW, 8: instruction register width; the opcode is IR[IW-1:IW-4]; IW >= 4.
- NT, 6: number of T-states per instruction cycle (ring length); NT >= FETCH+1.
- FETCH, 3: number of fetch states T[0]..T[FETCH-1]; FETCH >= 1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  clock enable; when low, every register holds.
- IR  in  IW  instruction register contents.
- ZF  in  1  zero flag, sampled at the latch edge.
- NF  in  1  negative flag, sampled at the latch edge.
- RUN  in  1  resume request; acted on only while HALTED=1.
- T  out  NT  one-hot T-state.
- ID  out  11  registered one-hot decode: bit0 LDA, bit1 STA, bit2 ADD, bit3 SUB, bit4 XOR, bit5 INC, bit6 CLR, bit7 JMP, bit8 JPZ, bit9 JPN, bit10 HLT.
- ILL  out  1  undefined opcode latched.
- JMP_TAKEN  out  1  jump resolved taken.
- HALTED  out  1  sequencer frozen by HLT.

## Operation
- Opcode map: LDA 0000, STA 0001, ADD 0010, SUB 0011, XOR 0100, INC 0110, CLR 0111, JMP 1000, JPN 1001, JPZ 1100, HLT 1111. The opcodes 0101, 1010, 1011, 1101 and 1110 are undefined.
- Reset values: T = 1 (T0), ID = 0, ILL = 0, JMP_TAKEN = 0, HALTED = 0.
- Ring: with EN=1 and not halted, T rotates left one position per clock. T[NT-1] wraps to T[0].
- Latch edge (T[FETCH-1] high):
  - ID <= decode(opcode).
  - ILL <= 1 if the opcode is undefined (ID = 0).
  - JMP_TAKEN <= JMP | (JPZ & ZF) | (JPN & NF).
- Wrap edge (T[NT-1] high): ID, ILL and JMP_TAKEN clear to 0. ID is therefore non-zero only during execute states.
- Undefined opcode: executes as a NOP. The ring runs normally and ILL is high for the whole execute window.
- Halt:
  - Trigger: edge with T[FETCH] high and ID[10]=1.
  - Effect: T holds at T[FETCH], HALTED <= 1, ID stays HLT.
  - Resume: while HALTED, an edge with RUN=1 sets T <= T0, ID/ILL/JMP_TAKEN <= 0, HALTED <= 0.
  - RUN is ignored when not halted.
- EN=0: T, ID, ILL, JMP_TAKEN and HALTED all hold. RUN is ignored.
- RST mid-operation forces the reset values immediately and asynchronously, including while halted.
- Internal opcode width is fixed at 4 bits; IR bits below IW-4 are ignored.

## Timing
- Outputs are all registered; no combinational path from inputs to outputs.
- IR, ZF and NF must be stable at the latch edge; changes afterwards have no effect until the next cycle.
- Decode latency: ID is valid on the cycle after the latch edge (T[FETCH]). It stays valid for NT-FETCH cycles.
- Halt latency: HALTED rises one cycle after T[FETCH] is entered with HLT.
- Resume latency: T0 appears one cycle after RUN is sampled high.
- Cycle period: NT clocks per instruction (EN=1).
- Simultaneous events:
  - RST dominates everything.
  - EN=0 dominates RUN and all edges.
  - When FETCH = NT-1, the latch edge and the wrap edge are distinct edges, so there is no conflict.

## Test plan
Defaults IW=8, NT=6, FETCH=3.
- Reset and ring: RST=1 -> T=6'b000001, ID=0, HALTED=0. Release, EN=1, 6 clocks -> T = 01, 02, 04, 08, 10, 20, then 01.
- Decode: IR=8'h2A across T2 -> ID=11'h004 during T3..T5, ILL=0. ID returns to 0 at T0. Repeat for all 11 opcodes with the bit positions listed above.
- Undefined opcode: IR=8'h5F -> ID=0 and ILL=1 during T3..T5; ring continues to T0.
- Jumps:
  - IR=8'hC3, ZF=1 -> ID=11'h100, JMP_TAKEN=1.
  - Same with ZF=0 -> JMP_TAKEN=0.
  - IR=8'h91, NF=1 -> ID=11'h200, JMP_TAKEN=1.
  - Toggling ZF after the latch edge leaves JMP_TAKEN unchanged.
- Halt/resume: IR=8'hF0 -> T frozen at 6'b001000 and HALTED=1 from the next cycle; stays frozen for 10 clocks. A one-cycle RUN pulse -> T=6'b000001, HALTED=0, ID=0.
- Enable/reset: EN=0 for 3 clocks during T4 -> T and ID unchanged. Then assert RST mid-cycle during T4 -> outputs take their reset values before the next CLK edge.
